// File: rtl/wm_door_lock_ctrl.sv
// Door-latch servo sequencer: lock/unlock handshake, settle and post-spin cooldown timing, faults.
// Optional WM_DOOR_AUTOCLR_EN: FAULT self-clears after a full tick with door closed and no lock request.
module wm_door_lock_ctrl #(
  parameter int unsigned SETTLE_TICKS   = 1000,
  parameter int unsigned COOLDOWN_TICKS = 4000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clkCnt_0p5msEnd,
  input  logic       lockReq,
  input  logic       doorClosed,
  input  logic       motorRunning,
  input  logic       faultClr,
  output logic       servoOpen,
  output logic       servoClose,
  output logic       doorLocked,
  output logic       doorBusy,
  output logic       doorFault,
  output logic [2:0] doorState
);

  typedef enum logic [2:0] {
    StInit       = 3'd0,
    StUnlocked   = 3'd1,
    StLockWait   = 3'd2,
    StLocked     = 3'd3,
    StUnlockHold = 3'd4,
    StUnlockWait = 3'd5,
    StFault      = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               open_d, close_d;
  logic               settle_done, cool_done;

  assign settle_done = clkCnt_0p5msEnd && (cnt_q == CNT_W'(SETTLE_TICKS - 1));
  assign cool_done   = clkCnt_0p5msEnd && (cnt_q == CNT_W'(COOLDOWN_TICKS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = clkCnt_0p5msEnd ? cnt_q + CNT_W'(1) : cnt_q;
    open_d  = 1'b0;
    close_d = 1'b0;
    unique case (state_q)
      StInit: begin
        open_d  = 1'b1;
        state_d = StUnlockWait;
      end
      StUnlocked: begin
        if (lockReq && doorClosed) begin
          close_d = 1'b1;
          state_d = StLockWait;
        end
      end
      StLockWait: begin
        if (!doorClosed) begin
          open_d  = 1'b1;
          state_d = StFault;
        end else if (settle_done) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (!doorClosed) begin
          open_d  = 1'b1;
          state_d = StFault;
        end else if (!lockReq) begin
          state_d = StUnlockHold;
        end
      end
      StUnlockHold: begin
        if (!doorClosed) begin
          open_d  = 1'b1;
          state_d = StFault;
        end else if (lockReq) begin
          state_d = StLocked;
        end else if (motorRunning) begin
          cnt_d = '0;
        end else if (cool_done) begin
          open_d  = 1'b1;
          state_d = StUnlockWait;
        end
      end
      StUnlockWait: begin
        if (settle_done) state_d = StUnlocked;
      end
      StFault: begin
`ifdef WM_DOOR_AUTOCLR_EN
        // Counter tracks ticks seen while the safe condition holds; the second one closes the interval.
        if (!doorClosed || lockReq) begin
          cnt_d = '0;
        end else if (clkCnt_0p5msEnd && (cnt_q == CNT_W'(1))) begin
          state_d = StUnlockWait;
        end
`endif
        if (faultClr && !lockReq) state_d = StUnlockWait;
      end
      default: state_d = StInit;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      servoOpen  <= 1'b0;
      servoClose <= 1'b0;
      doorLocked <= 1'b0;
      doorBusy   <= 1'b0;
      doorFault  <= 1'b0;
      doorState  <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      servoOpen  <= open_d;
      servoClose <= close_d;
      doorLocked <= (state_d == StLocked) || (state_d == StUnlockHold);
      doorBusy   <= (state_d == StInit) || (state_d == StLockWait) || (state_d == StUnlockWait);
      doorFault  <= (state_d == StFault);
      doorState  <= state_d;
    end
  end

endmodule

// File: tb/tb_wm_door_lock_ctrl.sv
// Directed bench for wm_door_lock_ctrl with SETTLE_TICKS=4, COOLDOWN_TICKS=6.
module tb_wm_door_lock_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic       lockReq = 1'b0;
  logic       doorClosed = 1'b0;
  logic       motorRunning = 1'b0;
  logic       faultClr = 1'b0;
  logic       servoOpen, servoClose, doorLocked, doorBusy, doorFault;
  logic [2:0] doorState;

  int vectors = 0;
  int miscompares = 0;

  wm_door_lock_ctrl #(
    .SETTLE_TICKS  (4),
    .COOLDOWN_TICKS(6),
    .CNT_W         (16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .clkCnt_0p5msEnd(tick),
    .lockReq        (lockReq),
    .doorClosed     (doorClosed),
    .motorRunning   (motorRunning),
    .faultClr       (faultClr),
    .servoOpen      (servoOpen),
    .servoClose     (servoClose),
    .doorLocked     (doorLocked),
    .doorBusy       (doorBusy),
    .doorFault      (doorFault),
    .doorState      (doorState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0;
  endtask

  // Closed door + lockReq from UNLOCKED, then a full settle into LOCKED.
  task automatic lock_up();
    lockReq = 1'b1;
    doorClosed = 1'b1;
    step();
    ticks(4);
  endtask

  initial begin
    step();
    step();
    check("rst_state", doorState, 0);
    check("rst_open", servoOpen, 0);
    check("rst_busy", doorBusy, 0);
    check("rst_locked", doorLocked, 0);
    check("rst_fault", doorFault, 0);

    rstn = 1'b1;
    step();
    check("init_open", servoOpen, 1);
    check("init_state", doorState, 5);
    check("init_busy", doorBusy, 1);
    step();
    check("init_open_end", servoOpen, 0);
    ticks(3);
    check("uw_3ticks", doorState, 5);
    ticks(1);
    check("uw_done_state", doorState, 1);
    check("uw_done_busy", doorBusy, 0);

    lockReq = 1'b1;
    step();
    step();
    check("req_open_state", doorState, 1);
    check("req_open_close", servoClose, 0);
    check("req_open_fault", doorFault, 0);

    doorClosed = 1'b1;
    step();
    check("lw_close", servoClose, 1);
    check("lw_open", servoOpen, 0);
    check("lw_state", doorState, 2);
    check("lw_busy", doorBusy, 1);
    step();
    check("lw_close_end", servoClose, 0);
    ticks(3);
    check("lw_3ticks_locked", doorLocked, 0);
    ticks(1);
    check("locked_state", doorState, 3);
    check("locked_flag", doorLocked, 1);
    check("locked_busy", doorBusy, 0);

    // Cooldown only begins once the motor stops.
    lockReq = 1'b0;
    motorRunning = 1'b1;
    step();
    check("hold_state", doorState, 4);
    check("hold_locked", doorLocked, 1);
    ticks(10);
    check("hold_motor_state", doorState, 4);
    check("hold_motor_open", servoOpen, 0);
    motorRunning = 1'b0;
    ticks(5);
    check("cool_5_state", doorState, 4);
    check("cool_5_open", servoOpen, 0);
    ticks(1);
    check("cool_6_open", servoOpen, 1);
    check("cool_6_state", doorState, 5);
    check("cool_6_locked", doorLocked, 0);
    step();
    check("cool_open_end", servoOpen, 0);
    ticks(4);
    check("unlocked_again", doorState, 1);

    // Motor blip at count 3 restarts the cooldown.
    lock_up();
    check("relock_state", doorState, 3);
    lockReq = 1'b0;
    step();
    ticks(3);
    motorRunning = 1'b1;
    step();
    motorRunning = 1'b0;
    ticks(5);
    check("restart_5_state", doorState, 4);
    check("restart_5_open", servoOpen, 0);
    ticks(1);
    check("restart_6_open", servoOpen, 1);
    check("restart_6_state", doorState, 5);
    ticks(4);

    lock_up();
    check("relock2_state", doorState, 3);
    doorClosed = 1'b0;
    step();
    check("fault_state", doorState, 6);
    check("fault_open", servoOpen, 1);
    check("fault_close", servoClose, 0);
    check("fault_flag", doorFault, 1);
    check("fault_locked", doorLocked, 0);
    step();
    check("fault_open_end", servoOpen, 0);
    faultClr = 1'b1;
    step();
    faultClr = 1'b0;
    check("clr_ignored", doorState, 6);
    lockReq = 1'b0;
    step();
    check("no_clr_stay", doorState, 6);
    faultClr = 1'b1;
    step();
    faultClr = 1'b0;
    check("clr_state", doorState, 5);
    check("clr_fault", doorFault, 0);
    check("clr_no_pulse", servoOpen, 0);
    check("clr_busy", doorBusy, 1);
    ticks(4);
    check("clr_unlocked", doorState, 1);

    // Fault with the door closed again and no request: self-clears only with the option.
    lock_up();
    doorClosed = 1'b0;
    step();
    check("fault2_state", doorState, 6);
    doorClosed = 1'b1;
    lockReq = 1'b0;
    step();
    ticks(1);
    check("autoclr_1tick", doorState, 6);
    ticks(1);
`ifdef WM_DOOR_AUTOCLR_EN
    check("autoclr_2tick", doorState, 5);
`else
    check("autoclr_2tick", doorState, 6);
    faultClr = 1'b1;
    step();
    faultClr = 1'b0;
    check("clr2_state", doorState, 5);
`endif
    ticks(4);
    check("unlocked_final", doorState, 1);

    // Reset while locked re-issues the open command.
    lock_up();
    check("pre_rst_state", doorState, 3);
    rstn = 1'b0;
    #2;
    check("midrst_state", doorState, 0);
    check("midrst_locked", doorLocked, 0);
    step();
    rstn = 1'b1;
    step();
    check("midrst_open", servoOpen, 1);
    check("midrst_close", servoClose, 0);
    check("midrst_after", doorState, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
